// File: rtl/spi_pkg.sv
// Shared types and constants for the two-requester SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 10;
  localparam int unsigned NUM_REQ       = 2;

endpackage

// File: rtl/spi_master_arb_if.sv
// Requester handshake and SPI pin bundle for spi_master_arb.
interface spi_master_arb_if #(
  parameter int unsigned width = spi_pkg::DEFAULT_WIDTH
) ();
  import spi_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [width-1:0]   tx_data0;
  logic [width-1:0]   tx_data1;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic [width-1:0]   rx_data;
  logic               busy;
  logic               sclk;
  logic               ssel;
  logic               mosi;
  logic               miso;

  modport master (
    input  req, tx_data0, tx_data1, miso,
    output grant, done, rx_data, busy, sclk, ssel, mosi
  );

  modport slave (
    output req, tx_data0, tx_data1, miso,
    input  grant, done, rx_data, busy, sclk, ssel, mosi
  );

endinterface

// File: rtl/spi_tick_gen.sv
// Half-period timer: one-cycle tick after clk_div cycles in the current state.
module spi_tick_gen #(
  parameter int unsigned clk_div = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_hold,
  output logic o_tick
);
  localparam int unsigned  CW   = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam logic [CW-1:0] LAST = CW'(clk_div - 1);

  logic [CW-1:0] r_cnt;

  // Every non-idle state change happens on a tick, so clearing on tick
  // (and holding at zero while idle) restarts the count on each state change.
  always_ff @(posedge clock) begin
    if (reset || i_hold || o_tick) r_cnt <= '0;
    else                           r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = !i_hold && (r_cnt == LAST);

endmodule

// File: rtl/spi_master_arb.sv
// Round-robin arbitrated SPI mode-0 master for two on-chip requesters.
module spi_master_arb
  import spi_pkg::*;
#(
  parameter int unsigned width    = DEFAULT_WIDTH,
  parameter int unsigned clk_div  = 4,
  parameter int unsigned ssel_gap = 2
) (
  input  logic             clock,
  input  logic             reset,
  spi_master_arb_if.master bus
);
  localparam int unsigned   BW       = $clog2(width + 1);
  localparam int unsigned   GW       = (ssel_gap > 1) ? $clog2(ssel_gap) : 1;
  localparam logic [BW-1:0] BITS     = BW'(width);
  localparam logic [GW-1:0] GAP_LAST = GW'(ssel_gap - 1);

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic               r_last;
  logic [width-1:0]   r_tx;
  logic [width-1:0]   r_rx;
  logic [width-1:0]   r_rx_data;
  logic [BW-1:0]      r_bitcnt;
  logic [GW-1:0]      r_gap;
  logic               r_sclk;
  logic               r_ssel;

  logic               w_idle;
  logic               w_tick;
  logic               w_win;
  logic [NUM_REQ-1:0] w_grant;
  logic [width-1:0]   w_tx_sel;

  assign w_idle = (r_state == S_IDLE);

  spi_tick_gen #(.clk_div(clk_div)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .i_hold (w_idle),
    .o_tick (w_tick)
  );

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    w_win = bus.req[1];
    if (&bus.req) w_win = ~r_last;
    w_grant  = w_win ? 2'b10 : 2'b01;
    w_tx_sel = w_win ? bus.tx_data1 : bus.tx_data0;
  end

  // Transfer sequencer: arbitration, sclk generation, shifting, framing.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_done    <= '0;
      r_last    <= 1'b1;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_bitcnt  <= '0;
      r_gap     <= '0;
      r_sclk    <= 1'b0;
      r_ssel    <= 1'b1;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_state  <= S_SETUP;
            r_grant  <= w_grant;
            r_last   <= w_win;
            r_tx     <= w_tx_sel;
            r_ssel   <= 1'b0;
            r_sclk   <= 1'b0;
            r_bitcnt <= BITS;
          end
        end
        S_SETUP: begin
          if (w_tick) begin
            r_state  <= S_HIGH;
            r_sclk   <= 1'b1;
            r_rx     <= {r_rx[width-2:0], bus.miso};
            r_bitcnt <= r_bitcnt - 1'b1;
          end
        end
        S_HIGH: begin
          // mosi is the tx register MSB; skipping the final shift holds the last bit.
          if (w_tick) begin
            r_state <= S_LOW;
            r_sclk  <= 1'b0;
            if (r_bitcnt != '0) r_tx <= r_tx << 1;
          end
        end
        S_LOW: begin
          if (w_tick) begin
            if (r_bitcnt == '0) begin
              r_state   <= S_GAP;
              r_ssel    <= 1'b1;
              r_done    <= r_grant;
              r_rx_data <= r_rx;
              r_gap     <= '0;
            end else begin
              r_state  <= S_HIGH;
              r_sclk   <= 1'b1;
              r_rx     <= {r_rx[width-2:0], bus.miso};
              r_bitcnt <= r_bitcnt - 1'b1;
            end
          end
        end
        S_GAP: begin
          r_grant <= '0;
          if (w_tick) begin
            if (r_gap == GAP_LAST) r_state <= S_IDLE;
            else                   r_gap   <= r_gap + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant   = r_grant;
  assign bus.done    = r_done;
  assign bus.rx_data = r_rx_data;
  assign bus.busy    = !w_idle;
  assign bus.sclk    = r_sclk;
  assign bus.ssel    = r_ssel;
  assign bus.mosi    = r_tx[width-1];

endmodule

// File: tb/tb_spi_master_arb.sv
// Self-checking bench for spi_master_arb: default build with a mode-0 slave
// model or loopback, plus a small clk_div=2/width=4 build in loopback.
module tb_spi_master_arb;
  localparam int unsigned WA = 10, DA = 4, GA = 2;
  localparam int unsigned WB = 4,  DB = 2, GB = 1;
  localparam int unsigned LAT_A     = DA * (2 * WA + 1);
  localparam int unsigned LAT_B     = DB * (2 * WB + 1);
  localparam int unsigned GAP_MIN_A = 1 + GA * DA;
  localparam int NV = 7;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  spi_master_arb_if #(.width(WA)) ifa ();
  spi_master_arb_if #(.width(WB)) ifb ();

  spi_master_arb #(.width(WA), .clk_div(DA), .ssel_gap(GA)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa)
  );

  spi_master_arb #(.width(WB), .clk_div(DB), .ssel_gap(GB)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int a_last   = 1;
  int b_last   = 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- mode-0 slave model on bus A ----------------
  logic          slave_mode = 1'b0;
  logic [WA-1:0] s_word  = '0;
  logic [WA-1:0] s_shift = '0;
  logic [WA-1:0] s_rx    = '0;
  logic [WA-1:0] s_recv  = '0;
  logic          s_miso  = 1'b0;
  int            s_bits  = 0;

  assign ifa.miso = slave_mode ? s_miso : ifa.mosi;
  assign ifb.miso = ifb.mosi;

  always @(negedge ifa.ssel) begin
    s_shift = s_word;
    s_miso  = s_shift[WA-1];
    s_bits  = 0;
  end
  always @(posedge ifa.sclk) if (ifa.ssel === 1'b0) begin
    s_rx = {s_rx[WA-2:0], ifa.mosi};
    s_bits++;
  end
  always @(negedge ifa.sclk) if (ifa.ssel === 1'b0 && s_bits < int'(WA)) begin
    s_shift = s_shift << 1;
    s_miso  = s_shift[WA-1];
  end
  always @(posedge ifa.ssel) s_recv = s_rx;

  // ---------------- bus A pin monitor ----------------
  logic pa_sclk = 1'b0, pa_mosi = 1'b0, pa_ssel = 1'b1, gap_armed = 1'b0;
  int   a_rises = 0, a_ssel_hi = 0;

  always @(negedge clock) begin
    if (reset) begin
      gap_armed = 1'b0;
    end else begin
      if (ifa.sclk === 1'b1 && pa_sclk === 1'b0) begin
        a_rises++;
        check("mosi_stable_at_sclk_rise", 32'(ifa.mosi), 32'(pa_mosi));
      end
      if (ifa.ssel === 1'b0 && pa_ssel === 1'b1 && gap_armed) begin
        n_checks++;
        if (a_ssel_hi < int'(GAP_MIN_A)) begin
          n_fail++;
          $display("FAIL ssel_gap: ssel high %0d cycles, required >= %0d", a_ssel_hi, GAP_MIN_A);
        end
      end
      if (ifa.done != '0) gap_armed = 1'b1;
    end
    a_ssel_hi = (ifa.ssel === 1'b1) ? a_ssel_hi + 1 : 0;
    pa_sclk = ifa.sclk;
    pa_mosi = ifa.mosi;
    pa_ssel = ifa.ssel;
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [1:0]    req;
    logic [WA-1:0] tx0;
    logic [WA-1:0] tx1;
    logic [WA-1:0] word;
    logic          smode;
    logic [1:0]    exp_grant;
    logic [WA-1:0] exp_rx;
  } vec_t;

  vec_t       vecs [NV];
  logic [1:0] held_seq [3];

  task automatic do_reset();
    @(negedge clock);
    reset   = 1'b1;
    ifa.req = '0;
    ifb.req = '0;
    repeat (3) @(negedge clock);
    reset  = 1'b0;
    a_last = 1;
    b_last = 1;
  endtask

  task automatic xfer_a(input logic [1:0] req, input logic [WA-1:0] tx0, input logic [WA-1:0] tx1,
                        input logic [WA-1:0] word, input logic smode, input logic [1:0] exp_grant,
                        input logic [WA-1:0] exp_rx, input int hold);
    int cyc;
    logic [WA-1:0] exp_sent;
    exp_sent = exp_grant[1] ? tx1 : tx0;
    cyc = 0;
    while (ifa.busy !== 1'b0 && cyc < 200) begin @(negedge clock); cyc++; end
    check("a_idle_before_req", 32'(ifa.busy), 32'd0);
    slave_mode   = smode;
    s_word       = word;
    ifa.tx_data0 = tx0;
    ifa.tx_data1 = tx1;
    ifa.req      = req;
    a_rises      = 0;
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (ifa.grant == '0 && cyc < 20);
    check("a_grant_latency", cyc, 1);
    check("a_grant", 32'(ifa.grant), 32'(exp_grant));
    check("a_ssel_low_at_grant", 32'(ifa.ssel), 32'd0);
    check("a_busy_at_grant", 32'(ifa.busy), 32'd1);
    ifa.tx_data0 = ~tx0;
    ifa.tx_data1 = ~tx1;
    if (hold == 0) ifa.req = '0;
    cyc = 0;
    while (ifa.done == '0 && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (cyc == hold) ifa.req = '0;
    end
    check("a_done_latency", cyc, LAT_A);
    check("a_done", 32'(ifa.done), 32'(exp_grant));
    check("a_grant_in_done_cycle", 32'(ifa.grant), 32'(exp_grant));
    check("a_rx_data", 32'(ifa.rx_data), 32'(exp_rx));
    check("a_sclk_rises", a_rises, WA);
    check("a_ssel_high_at_done", 32'(ifa.ssel), 32'd1);
    @(negedge clock);
    check("a_done_one_cycle", 32'(ifa.done), 32'd0);
    check("a_grant_dropped", 32'(ifa.grant), 32'd0);
    check("a_rx_data_held", 32'(ifa.rx_data), 32'(exp_rx));
    if (smode) check("a_slave_received", 32'(s_recv), 32'(exp_sent));
    a_last = exp_grant[1] ? 1 : 0;
  endtask

  task automatic xfer_b(input logic [1:0] req, input logic [WB-1:0] tx0, input logic [WB-1:0] tx1,
                        input logic [1:0] exp_grant, input logic [WB-1:0] exp_rx);
    int   cyc, rises, run;
    logic prev;
    cyc = 0;
    while (ifb.busy !== 1'b0 && cyc < 100) begin @(negedge clock); cyc++; end
    check("b_idle_before_req", 32'(ifb.busy), 32'd0);
    ifb.tx_data0 = tx0;
    ifb.tx_data1 = tx1;
    ifb.req      = req;
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (ifb.grant == '0 && cyc < 20);
    check("b_grant_latency", cyc, 1);
    check("b_grant", 32'(ifb.grant), 32'(exp_grant));
    ifb.tx_data0 = ~tx0;
    ifb.tx_data1 = ~tx1;
    ifb.req      = '0;
    cyc   = 0;
    rises = 0;
    run   = 1;
    prev  = ifb.sclk;
    while (ifb.done == '0 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (ifb.sclk !== prev) begin
        check(prev ? "b_sclk_high_half" : "b_sclk_low_half", run, DB);
        if (ifb.sclk === 1'b1) rises++;
        run = 1;
      end else begin
        run++;
      end
      prev = ifb.sclk;
    end
    check("b_done_latency", cyc, LAT_B);
    check("b_done", 32'(ifb.done), 32'(exp_grant));
    check("b_rx_data", 32'(ifb.rx_data), 32'(exp_rx));
    check("b_sclk_rises", rises, WB);
    @(negedge clock);
    check("b_done_one_cycle", 32'(ifb.done), 32'd0);
    b_last = exp_grant[1] ? 1 : 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc, done_seen, winner;
    logic [1:0]    rq, eg;
    logic [WA-1:0] t0, t1, w, er;
    logic          sm;
    logic [WB-1:0] u0, u1;

    vecs[0] = '{2'b01, 10'h2A5, 10'h000, 10'h000, 1'b0, 2'b01, 10'h2A5};
    vecs[1] = '{2'b10, 10'h000, 10'h15A, 10'h3C3, 1'b1, 2'b10, 10'h3C3};
    vecs[2] = '{2'b11, 10'h3FF, 10'h001, 10'h000, 1'b0, 2'b01, 10'h3FF};
    vecs[3] = '{2'b11, 10'h000, 10'h200, 10'h155, 1'b1, 2'b10, 10'h155};
    vecs[4] = '{2'b01, 10'h001, 10'h000, 10'h000, 1'b1, 2'b01, 10'h000};
    vecs[5] = '{2'b01, 10'h200, 10'h000, 10'h000, 1'b0, 2'b01, 10'h200};
    vecs[6] = '{2'b11, 10'h123, 10'h0AB, 10'h2DB, 1'b1, 2'b10, 10'h2DB};
    held_seq = '{2'b01, 2'b10, 2'b01};

    ifa.req = '0; ifa.tx_data0 = '0; ifa.tx_data1 = '0;
    ifb.req = '0; ifb.tx_data0 = '0; ifb.tx_data1 = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check("rst_a_sclk", 32'(ifa.sclk), 32'd0);
    check("rst_a_ssel", 32'(ifa.ssel), 32'd1);
    check("rst_a_mosi", 32'(ifa.mosi), 32'd0);
    check("rst_a_grant", 32'(ifa.grant), 32'd0);
    check("rst_a_done", 32'(ifa.done), 32'd0);
    check("rst_a_rx_data", 32'(ifa.rx_data), 32'd0);
    check("rst_a_busy", 32'(ifa.busy), 32'd0);
    check("rst_b_ssel", 32'(ifb.ssel), 32'd1);
    check("rst_b_busy", 32'(ifb.busy), 32'd0);

    for (int i = 0; i < NV; i++)
      xfer_a(vecs[i].req, vecs[i].tx0, vecs[i].tx1, vecs[i].word, vecs[i].smode,
             vecs[i].exp_grant, vecs[i].exp_rx, 1);

    // Randomized transfers against the round-robin reference.
    for (int i = 0; i < 10; i++) begin
      rq = 2'($urandom_range(1, 3));
      t0 = WA'($urandom);
      t1 = WA'($urandom);
      w  = WA'($urandom);
      sm = 1'($urandom);
      if (rq == 2'b11) winner = 1 - a_last;
      else             winner = (rq == 2'b10) ? 1 : 0;
      eg = 2'(1 << winner);
      er = sm ? w : ((winner == 1) ? t1 : t0);
      xfer_a(rq, t0, t1, w, sm, eg, er, 1);
    end

    // Request withdrawn mid-transfer still completes.
    xfer_a(2'b01, 10'h0F0, 10'h30F, 10'h000, 1'b0, 2'b01, 10'h0F0, 5);

    // Both requests held continuously: grants alternate.
    do_reset();
    slave_mode   = 1'b0;
    ifa.tx_data0 = 10'h111;
    ifa.tx_data1 = 10'h222;
    ifa.req      = 2'b11;
    for (int k = 0; k < 3; k++) begin
      cyc = 0;
      while (ifa.grant == '0 && cyc < 200) begin @(negedge clock); cyc++; end
      check("held_grant", 32'(ifa.grant), 32'(held_seq[k]));
      if (k == 2) ifa.req = '0;
      cyc = 0;
      while (ifa.grant != '0 && cyc < 200) begin @(negedge clock); cyc++; end
      check("held_rx_data", 32'(ifa.rx_data), (k == 1) ? 32'h222 : 32'h111);
    end

    // Reset in the middle of a transfer.
    cyc = 0;
    while (ifa.busy !== 1'b0 && cyc < 200) begin @(negedge clock); cyc++; end
    ifa.tx_data0 = 10'h3A5;
    ifa.req      = 2'b01;
    cyc = 0;
    while (ifa.grant == '0 && cyc < 20) begin @(negedge clock); cyc++; end
    check("midrst_grant", 32'(ifa.grant), 32'd1);
    ifa.req = '0;
    repeat (30) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_ssel", 32'(ifa.ssel), 32'd1);
    check("midrst_sclk", 32'(ifa.sclk), 32'd0);
    check("midrst_grant_clear", 32'(ifa.grant), 32'd0);
    check("midrst_rx_data", 32'(ifa.rx_data), 32'd0);
    check("midrst_busy", 32'(ifa.busy), 32'd0);
    reset  = 1'b0;
    a_last = 1;
    b_last = 1;
    done_seen = 0;
    repeat (120) begin
      @(negedge clock);
      if (ifa.done != '0) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    xfer_a(2'b01, 10'h0C3, 10'h000, 10'h000, 1'b0, 2'b01, 10'h0C3, 1);

    // Small build: clk_div=2, width=4.
    xfer_b(2'b01, 4'hA, 4'h0, 2'b01, 4'hA);
    for (int i = 0; i < 6; i++) begin
      rq = 2'($urandom_range(1, 3));
      u0 = WB'($urandom);
      u1 = WB'($urandom);
      if (rq == 2'b11) winner = 1 - b_last;
      else             winner = (rq == 2'b10) ? 1 : 0;
      eg = 2'(1 << winner);
      xfer_b(rq, u0, u1, eg, (winner == 1) ? u1 : u0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_arb.md
# spi_master_arb

Two-requester SPI master that sequences complete word transfers to the team's SPI slave (mode 0: sclk idles low, slave samples mosi on sclk rise, slave updates miso on sclk fall). It divides the system clock into sclk and frames each word with active-low ssel. It shifts tx data out MSB-first and captures miso into rx_data. Two on-chip requesters share the single bus through a round-robin arbiter.

## Interface
- width, 10, bits per transfer; must equal the slave's width; ≥2
- clk_div, 4, system clocks per sclk half-period; ≥2
- ssel_gap, 2, sclk half-periods ssel stays high between transfers; ≥1

- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  2  per-requester transfer request, level
- tx_data0  in  width  requester 0 word, captured at grant
- tx_data1  in  width  requester 1 word, captured at grant
- grant  out  2  one-hot; high from grant cycle through done cycle
- done  out  2  one-cycle pulse to the owning requester at end of transfer
- rx_data  out  width  received word; updated in the done cycle, held until next done
- busy  out  1  high whenever state ≠ IDLE
- sclk  out  1  SPI clock
- ssel  out  1  SPI select, active-low
- mosi  out  1  SPI data out
- miso  in  1  SPI data in

## Operation
- States: IDLE, SETUP, HIGH, LOW, GAP.
- IDLE, any req high:
  - grant the winner and capture its tx_data into the shift register;
  - drive ssel=0, sclk=0, mosi=tx MSB;
  - load bit counter = width; go to SETUP.
- Arbitration is round-robin with a last-served pointer.
  - With both requests high, the requester not last served wins.
  - Pointer resets to 1, so requester 0 wins the first tie.
- SETUP (clk_div cycles) → HIGH.
- HIGH, entry cycle:
  - sclk=1;
  - miso sampled into rx shift register LSB, shifting left;
  - bit counter decrements.
  - After clk_div cycles → LOW.
- LOW, entry cycle: sclk=0.
  - If bits remain, mosi = next bit; after clk_div cycles → HIGH.
  - If bit counter = 0, mosi holds its last value. After clk_div cycles:
    - ssel=1, the done bit for the owner pulses, rx_data updated;
    - grant drops the next cycle;
    - go to GAP.
- GAP: ssel_gap·clk_div cycles → IDLE. req is not examined during GAP.
- req dropped mid-transfer is ignored; the transfer completes and done still pulses.
- req still high after done is treated as a new request at the next IDLE.
- Half-period counter width is clog2(clk_div). Bit counter width is clog2(width+1).

## Timing
- Reset values:
  - sclk=0, ssel=1, mosi=0;
  - grant=0, done=0, rx_data=0, busy=0;
  - state=IDLE, pointer=1.
- Reset mid-transfer:
  - ssel=1 and sclk=0 on the next edge;
  - no done pulse; rx_data=0.
- Grant occurs 1 cycle after req is sampled in IDLE. ssel falls in the same cycle as grant.
- done rises clk_div·(2·width+1) cycles after grant: 84 cycles for the defaults.
- Back-to-back transfers: the next grant is no earlier than 1 + ssel_gap·clk_div cycles after done.
- sclk rises exactly width times per frame.
- mosi changes only while sclk is low, and never in the same cycle sclk rises.
- ssel rises no earlier than clk_div cycles after the last sclk fall.

## Structure
- Package spi_pkg:
  - state enum;
  - default width constant 10;
  - requester count constant 2.
- Sub-module spi_tick_gen:
  - half-period counter;
  - restarts on state change;
  - emits a one-cycle tick after clk_div cycles.
- Top level holds the FSM, the arbiter, the bit counter, and the tx/rx shift registers.

## Test plan
- Loopback (miso tied to mosi), req0 with tx_data0=10'h2A5 → grant=2'b01 one cycle later; done=2'b01 84 cycles after grant; rx_data=10'h2A5; exactly 10 sclk rises.
- Slave model attached, req1 with tx_data1=10'h15A → slave data_recieved=10'h15A once ssel rises; mosi stable across every sclk rise.
- req=2'b11 held continuously → grants alternate 01, 10, 01; GAP between frames ≥ 8 cycles with ssel high.
- req0 dropped 5 cycles after grant → transfer completes; done[0] still pulses.
- reset asserted 30 cycles into a transfer → next edge ssel=1, sclk=0, grant=0; no done; a fresh req0 afterwards completes normally.
- clk_div=2, width=4 → done 18 cycles after grant; each sclk half-period is 2 cycles.
